// File: rtl/event_encoder_8to3.sv
// event_encoder_8to3: registered 8-to-3 priority encoder for board-level
// request lines. Synchronises and debounces the raw input vector, latches
// each debounced rising edge as a pending event, and issues the
// highest-index pending event as a 3-bit code on a valid/ready handshake.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      asynchronous, active-high reset
//   en       event capture enable (0 clears pending, blocks new loads)
//   in[7:0]  raw request lines, asynchronous to clk; bit 7 has top priority
//   code     index of the serviced event (registered)
//   valid    code holds an unaccepted event (registered)
//   ready    consumer accepts code when valid && ready at a clock edge
//   pending  latched, not-yet-serviced events (registered)
//   drop     one-cycle pulse: a rising edge hit an already-pending bit
module event_encoder_8to3 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       drop
);

  // Counter wide enough for the largest legal DEBOUNCE_CYCLES (1023).
  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync_d;
  logic [7:0]       sync_q;
  logic [7:0]       sync_prev;
  logic [7:0]       db;
  logic [CNT_W-1:0] cnt;

  logic             stable;
  logic             db_load;
  logic [7:0]       rise;
  logic             any_pending;
  logic [2:0]       top_idx;
  logic             load;
  logic [7:0]       load_mask;
  logic [7:0]       pending_nxt;
  logic             drop_nxt;

  // Debounce acceptance and edge detection on the accepted vector.
  always_comb begin
    stable  = (sync_q == sync_prev);
    db_load = stable && (cnt == CNT_MAX);
    rise    = db_load ? (sync_q & ~db) : 8'h00;
  end

  // Highest set pending bit; later iterations override earlier ones.
  always_comb begin
    top_idx     = 3'd0;
    any_pending = |pending;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) top_idx = 3'(i);
    end
  end

  // Load decision and pending/drop next state. A rise on the bit being
  // loaded re-sets it (set wins) and is a fresh event, not a drop.
  always_comb begin
    load        = (!valid || ready) && en && any_pending;
    load_mask   = load ? (8'd1 << top_idx) : 8'h00;
    pending_nxt = en ? ((pending & ~load_mask) | rise) : 8'h00;
    drop_nxt    = en && (|(rise & pending & ~load_mask));
  end

  // Synchroniser, debounce and output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d    <= 8'h00;
      sync_q    <= 8'h00;
      sync_prev <= 8'h00;
      db        <= 8'h00;
      cnt       <= '0;
      pending   <= 8'h00;
      code      <= 3'd0;
      valid     <= 1'b0;
      drop      <= 1'b0;
    end else begin
      sync_d    <= in;
      sync_q    <= sync_d;
      sync_prev <= sync_q;
      if (!stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (db_load) db <= sync_q;
      pending <= pending_nxt;
      drop    <= drop_nxt;
      if (load) begin
        code  <= top_idx;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
